pc_ras: RTL and testbench

Next-generation program counter with a built-in hardware return-address stack (RAS).
Supports sequential increment, absolute jump, signed relative branch, subroutine call and return, all parametrised in address width and stack depth.
Sits between the instruction decoder (command strobes, target/offset) and instruction memory (crnt_adr).
Reports stack occupancy and flags stack misuse for debug and trap logic.

---
 rtl/pc_pkg.sv | 32 +++
 rtl/pc_ras_stack.sv | 55 +++++
 rtl/pc_ras.sv | 106 ++++++++++
 tb/tb_pc_ras.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the return-address-stack program counter: command encoding and defaults.
// Latency: none (types only); Backpressure: n/a.
package pc_pkg;

  localparam int PC_WIDTH  = 8;
  localparam int RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INC,
    CMD_BRANCH,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET,
    CMD_ILLEGAL
  } cmd_e;

  // Strobes resolved to a single action; call+ret together is the only illegal mix.
  function automatic cmd_e decode_cmd(input logic en, input logic call, input logic ret,
                                      input logic load, input logic branch);
    cmd_e c;
    if (!en)              c = CMD_NONE;
    else if (call && ret) c = CMD_ILLEGAL;
    else if (ret)         c = CMD_RET;
    else if (call)        c = CMD_CALL;
    else if (load)        c = CMD_LOAD;
    else if (branch)      c = CMD_BRANCH;
    else                  c = CMD_INC;
    return c;
  endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// Generic WIDTH x DEPTH LIFO: push at depth, pop exposes entry depth-1 combinationally.
// Latency: 1 cycle for depth update; Backpressure: push when full / pop when empty are ignored.
module pc_ras_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    depth_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign depth_o = cnt_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;

  always_comb begin
    dout_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) dout_o = mem_q[i];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (do_push)     cnt_d = cnt_q + CW'(1);
    else if (do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Entries carry no reset: contents are meaningless once the count is cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && cnt_q == CW'(i)) mem_q[i] <= din_i;
    end
  end

endmodule

// File: rtl/pc_ras.sv
// Program counter with increment/jump/branch/call/return and a built-in return-address stack.
// Latency: 1 cycle strobe-to-crnt_adr; Backpressure: enable=0 stalls everything, misuse is dropped and flagged.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH     = PC_WIDTH,
  parameter int DEPTH     = RAS_DEPTH,
  parameter int OFS_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       load,
  input  logic                       branch,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           nxt_adr,
  input  logic [OFS_WIDTH-1:0]       offset,
  output logic [WIDTH-1:0]           crnt_adr,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       err_ovf,
  output logic                       err_unf,
  output logic                       err_cmd
);

  localparam int CW = $clog2(DEPTH + 1);

  cmd_e             cmd;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc, ofs_ext, ras_top;
  logic             push, pop;
  logic             ovf_q, ovf_d, unf_q, unf_d, ecmd_q, ecmd_d;

  assign cmd     = decode_cmd(enable, call, ret, load, branch);
  assign pc_inc  = pc_q + WIDTH'(1);
  assign ofs_ext = WIDTH'($signed(offset));

  always_comb begin
    pc_d   = pc_q;
    push   = 1'b0;
    pop    = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    ecmd_d = 1'b0;
    unique case (cmd)
      CMD_ILLEGAL: ecmd_d = 1'b1;
      CMD_RET: begin
        if (empty) unf_d = 1'b1;
        else begin
          pc_d = ras_top;
          pop  = 1'b1;
        end
      end
      // A call on a full stack is dropped whole so the stacked entries stay intact.
      CMD_CALL: begin
        if (full) ovf_d = 1'b1;
        else begin
          pc_d = nxt_adr;
          push = 1'b1;
        end
      end
      CMD_LOAD:   pc_d = nxt_adr;
      CMD_BRANCH: pc_d = pc_q + ofs_ext;
      CMD_INC:    pc_d = pc_inc;
      default:    pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      ecmd_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      ecmd_q <= ecmd_d;
    end
  end

  pc_ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_stack (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_inc),
    .dout_o  (ras_top),
    .depth_o (depth),
    .full_o  (full),
    .empty_o (empty)
  );

  assign crnt_adr = pc_q;
  assign err_ovf  = ovf_q;
  assign err_unf  = unf_q;
  assign err_cmd  = ecmd_q;

endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras (WIDTH=8, DEPTH=4): each task drives a scenario and checks
// {crnt_adr, depth, full, empty, err_ovf, err_unf, err_cmd} against hand-computed values.
module tb_pc_ras;

  logic       clk = 1'b0;
  logic       reset, enable, load, branch, call, ret;
  logic [7:0] nxt_adr, offset;
  logic [7:0] crnt_adr;
  logic [2:0] depth;
  logic       full, empty, err_ovf, err_unf, err_cmd;

  int tests = 0;
  int fails = 0;

  logic [15:0] obs;
  assign obs = {crnt_adr, depth, full, empty, err_ovf, err_unf, err_cmd};

  pc_ras #(.WIDTH(8), .DEPTH(4), .OFS_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .branch   (branch),
    .call     (call),
    .ret      (ret),
    .nxt_adr  (nxt_adr),
    .offset   (offset),
    .crnt_adr (crnt_adr),
    .depth    (depth),
    .full     (full),
    .empty    (empty),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf),
    .err_cmd  (err_cmd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of strobes, then advance past the edge that samples them.
  task automatic step(input logic en, input logic c, input logic r, input logic l,
                      input logic b, input logic [7:0] nxt, input logic [7:0] ofs);
    enable = en; call = c; ret = r; load = l; branch = b; nxt_adr = nxt; offset = ofs;
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    exp = {8'h00, 3'd0, 5'b01000};
    if (obs !== exp) begin fails++; $display("FAIL reset_state got=%h exp=%h", obs, exp); end
    tests++;
    reset = 1'b1;
  endtask

  task automatic test_increment_wrap();
    logic [15:0] exp;
    int          bad = 0;
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      exp = {8'(i + 1), 3'd0, 5'b01000};
      if (obs !== exp) begin
        fails++;
        if (bad < 5) $display("FAIL inc_cycle_%0d got=%h exp=%h", i, obs, exp);
        bad++;
      end
      tests++;
    end
  endtask

  task automatic test_branch();
    logic [15:0] exp;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    exp = {8'h10, 3'd0, 5'b01000};
    if (obs !== exp) begin fails++; $display("FAIL load_10 got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hF0);
    exp = {8'h00, 3'd0, 5'b01000};
    if (obs !== exp) begin fails++; $display("FAIL branch_neg16 got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h7F);
    exp = {8'h7F, 3'd0, 5'b01000};
    if (obs !== exp) begin fails++; $display("FAIL branch_pos7f got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    exp = {8'h7F, 3'd0, 5'b01000};
    if (obs !== exp) begin fails++; $display("FAIL branch_self got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h80);
    exp = {8'hFF, 3'd0, 5'b01000};
    if (obs !== exp) begin fails++; $display("FAIL branch_neg128_wrap got=%h exp=%h", obs, exp); end
    tests++;
  endtask

  task automatic test_call_ret();
    logic [15:0] exp;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00);
    exp = {8'h80, 3'd1, 5'b00000};
    if (obs !== exp) begin fails++; $display("FAIL call_80 got=%h exp=%h", obs, exp); end
    tests++;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    exp = {8'h83, 3'd1, 5'b00000};
    if (obs !== exp) begin fails++; $display("FAIL sub_inc got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    exp = {8'h21, 3'd0, 5'b01000};
    if (obs !== exp) begin fails++; $display("FAIL ret_21 got=%h exp=%h", obs, exp); end
    tests++;
  endtask

  task automatic test_nested();
    logic [15:0] exp;
    logic [7:0]  rets [4];
    rets[0] = 8'h32; rets[1] = 8'h22; rets[2] = 8'h12; rets[3] = 8'h02;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h21, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h31, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 8'h00);
    exp = {8'h40, 3'd4, 5'b10000};
    if (obs !== exp) begin fails++; $display("FAIL nest_full got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h99, 8'h00);
    exp = {8'h40, 3'd4, 5'b10100};
    if (obs !== exp) begin fails++; $display("FAIL overflow got=%h exp=%h", obs, exp); end
    tests++;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      exp = {rets[i], 3'(3 - i), (i == 3) ? 5'b01000 : 5'b00000};
      if (obs !== exp) begin fails++; $display("FAIL nest_ret_%0d got=%h exp=%h", i, obs, exp); end
      tests++;
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    exp = {8'h02, 3'd0, 5'b01010};
    if (obs !== exp) begin fails++; $display("FAIL underflow got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    exp = {8'h02, 3'd0, 5'b01000};
    if (obs !== exp) begin fails++; $display("FAIL unf_pulse_clear got=%h exp=%h", obs, exp); end
    tests++;
  endtask

  task automatic test_cmd_conflicts();
    logic [15:0] exp;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h50, 8'h00);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77, 8'h00);
    exp = {8'h50, 3'd1, 5'b00001};
    if (obs !== exp) begin fails++; $display("FAIL call_and_ret got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 8'h05);
    exp = {8'h66, 3'd1, 5'b00000};
    if (obs !== exp) begin fails++; $display("FAIL load_over_branch got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 8'h05);
    exp = {8'h66, 3'd1, 5'b00000};
    if (obs !== exp) begin fails++; $display("FAIL disabled_all got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 8'h00);
    exp = {8'h66, 3'd1, 5'b00000};
    if (obs !== exp) begin fails++; $display("FAIL disabled_call got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    exp = {8'h03, 3'd0, 5'b01000};
    if (obs !== exp) begin fails++; $display("FAIL ret_after_conflicts got=%h exp=%h", obs, exp); end
    tests++;
  endtask

  task automatic test_async_reset();
    logic [15:0] exp;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    exp = {8'h45, 3'd2, 5'b00000};
    if (obs !== exp) begin fails++; $display("FAIL pre_reset got=%h exp=%h", obs, exp); end
    tests++;
    #2 reset = 1'b0;
    #1;
    exp = {8'h00, 3'd0, 5'b01000};
    if (obs !== exp) begin fails++; $display("FAIL async_reset got=%h exp=%h", obs, exp); end
    tests++;
    tick();
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    exp = {8'h01, 3'd0, 5'b01000};
    if (obs !== exp) begin fails++; $display("FAIL resume_1 got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    exp = {8'h02, 3'd0, 5'b01000};
    if (obs !== exp) begin fails++; $display("FAIL resume_2 got=%h exp=%h", obs, exp); end
    tests++;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    exp = {8'h02, 3'd0, 5'b01010};
    if (obs !== exp) begin fails++; $display("FAIL stack_discarded got=%h exp=%h", obs, exp); end
    tests++;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; load = 1'b0; branch = 1'b0;
    call = 1'b0; ret = 1'b0; nxt_adr = 8'h00; offset = 8'h00;
    #1;
    test_reset();
    test_increment_wrap();
    test_branch();
    test_call_ret();
    test_nested();
    test_cmd_conflicts();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
